regfile_writeback: RTL and testbench

Write-back initiator for the register file write port. It accepts results from two producers, the ALU and the load/store unit, each over a valid/ready handshake, and arbitrates between them round-robin. Accepted results are buffered in a small in-order FIFO, and the block drives the register file's `wr_addr_in` / `wr_data_in` / `wr_data_valid_in` / `wr_data_ready_out` handshake from the other end. It also exports a pending-write mask for hazard detection.

---
 rtl/regfile_wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 80 ++++++++
 rtl/regfile_writeback.sv | 128 ++++++++++++
 tb/tb_regfile_writeback.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back initiator.
package regfile_wb_pkg;

  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  localparam logic [15:0] WB_DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back buffer; exposes every slot plus an occupancy mask so the
// parent can decode pending destinations.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = wb_req_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output T                       head,
  output logic [DEPTH-1:0]       occ_valid,
  output T                       occ [DEPTH]
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T               mem [DEPTH];
  T               hold;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt;
  logic           do_push;
  logic           do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // An empty buffer keeps showing the most recently drained entry.
  assign head = empty ? hold : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      hold   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        hold   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off          = PW'(i) - rd_ptr;
      occ[i]       = mem[i];
      occ_valid[i] = ({1'b0, off} < cnt);
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Round-robin write-back initiator: ALU and LSU results are arbitrated,
// x0 writes dropped, the rest buffered and drained to the register file.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        alu_addr_in,
  input  logic [DATA_WIDTH-1:0]        alu_data_in,
  input  logic                         alu_valid_in,
  output logic                         alu_ready_out,
  input  logic [ADDR_WIDTH-1:0]        lsu_addr_in,
  input  logic [DATA_WIDTH-1:0]        lsu_data_in,
  input  logic                         lsu_valid_in,
  output logic                         lsu_ready_out,
  output logic [ADDR_WIDTH-1:0]        wr_addr_out,
  output logic [DATA_WIDTH-1:0]        wr_data_out,
  output logic                         wr_data_valid_out,
  input  logic                         wr_data_ready_in,
  output logic [2**ADDR_WIDTH-1:0]     pending_mask_out,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_out,
  output logic [15:0]                  drop_count_out
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  wb_src_e                      last_grant;
  logic                         grant_alu_c;
  logic                         grant_lsu_c;
  logic                         full;
  logic                         empty;
  logic                         accept;
  logic                         is_x0;
  logic                         push;
  logic                         pop;
  req_t                         sel_req;
  req_t                         head;
  req_t                         occ [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]        occ_valid;
  logic [$clog2(FIFO_DEPTH):0]  count;
  logic [15:0]                  drop_count;

  // On contention the source that did not win last time is granted.
  always_comb begin
    grant_alu_c = 1'b0;
    grant_lsu_c = 1'b0;
    if (alu_valid_in && lsu_valid_in) begin
      if (last_grant == WB_SRC_LSU) grant_alu_c = 1'b1;
      else                          grant_lsu_c = 1'b1;
    end else begin
      grant_alu_c = alu_valid_in;
      grant_lsu_c = lsu_valid_in;
    end
  end

  assign alu_ready_out = grant_alu_c && !full && rst;
  assign lsu_ready_out = grant_lsu_c && !full && rst;
  assign accept        = alu_ready_out || lsu_ready_out;

  always_comb begin
    sel_req = '0;
    if (grant_alu_c) begin
      sel_req.addr = alu_addr_in;
      sel_req.data = alu_data_in;
    end else begin
      sel_req.addr = lsu_addr_in;
      sel_req.data = lsu_data_in;
    end
  end

  assign is_x0 = (sel_req.addr == '0);
  assign push  = accept && !is_x0;
  assign pop   = !empty && wr_data_ready_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= WB_SRC_LSU;
      drop_count <= '0;
    end else if (accept) begin
      last_grant <= grant_alu_c ? WB_SRC_ALU : WB_SRC_LSU;
      if (is_x0 && (drop_count != WB_DROP_MAX)) begin
        drop_count <= drop_count + 16'(1);
      end
    end
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (sel_req),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head),
    .occ_valid (occ_valid),
    .occ       (occ)
  );

  // x0 is never enqueued, but bit 0 is forced low regardless.
  always_comb begin
    pending_mask_out = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (occ_valid[i]) begin
        pending_mask_out[occ[i].addr] = 1'b1;
      end
    end
    pending_mask_out[0] = 1'b0;
  end

  assign wr_addr_out       = head.addr;
  assign wr_data_out       = head.data;
  assign wr_data_valid_out = !empty;
  assign fifo_count_out    = count;
  assign drop_count_out    = drop_count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_regfile_writeback;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  lsu_addr = '0;
  logic [31:0] lsu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [31:0] mask;
  logic [2:0]  count;
  logic [15:0] drops;

  regfile_writeback #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .alu_addr_in       (alu_addr),
    .alu_data_in       (alu_data),
    .alu_valid_in      (alu_valid),
    .alu_ready_out     (alu_ready),
    .lsu_addr_in       (lsu_addr),
    .lsu_data_in       (lsu_data),
    .lsu_valid_in      (lsu_valid),
    .lsu_ready_out     (lsu_ready),
    .wr_addr_out       (wr_addr),
    .wr_data_out       (wr_data),
    .wr_data_valid_out (wr_valid),
    .wr_data_ready_in  (wr_ready),
    .pending_mask_out  (mask),
    .fifo_count_out    (count),
    .drop_count_out    (drops)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: pending writes as a queue, plus arbitration history.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_last_lsu = 1'b1;
  logic [15:0] m_drops = '0;
  logic [4:0]  m_hold_a = '0;
  logic [31:0] m_hold_d = '0;
  logic [4:0]  drain_log[$];

  always @(negedge rst) begin
    q.delete();
    m_last_lsu = 1'b1;
    m_drops    = '0;
    m_hold_a   = '0;
    m_hold_d   = '0;
  end

  function automatic void exp_ready(output logic ar, output logic lr);
    logic room;
    room = (q.size() < DEPTH);
    ar = rst && room && alu_valid && (!lsu_valid || m_last_lsu);
    lr = rst && room && lsu_valid && (!alu_valid || !m_last_lsu);
  endfunction

  always @(posedge clk) begin
    logic ea, el;
    ent_t e;
    if (rst) begin
      exp_ready(ea, el);
      if (q.size() > 0 && wr_ready) begin
        m_hold_a = q[0].a;
        m_hold_d = q[0].d;
        void'(q.pop_front());
      end
      if (ea || el) begin
        m_last_lsu = el;
        e.a = ea ? alu_addr : lsu_addr;
        e.d = ea ? alu_data : lsu_data;
        if (e.a == 5'd0) begin
          if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        end else begin
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic ea, el;
    logic [31:0] em;
    exp_ready(ea, el);
    em = '0;
    foreach (q[i]) em[q[i].a] = 1'b1;
    em[0] = 1'b0;
    chk("cyc_alu_ready", alu_ready, ea);
    chk("cyc_lsu_ready", lsu_ready, el);
    chk("cyc_wr_valid", wr_valid, q.size() != 0);
    chk("cyc_wr_addr", wr_addr, (q.size() != 0) ? q[0].a : m_hold_a);
    chk("cyc_wr_data", wr_data, (q.size() != 0) ? q[0].d : m_hold_d);
    chk("cyc_mask", mask, em);
    chk("cyc_count", count, q.size());
    chk("cyc_drops", drops, m_drops);
    if (wr_valid && wr_ready) drain_log.push_back(wr_addr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Holds one request until its handshake completes or the budget runs out.
  task automatic send(input logic is_alu, input logic [4:0] a, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    if (is_alu) begin alu_addr = a; alu_data = d; alu_valid = 1'b1; end
    else        begin lsu_addr = a; lsu_data = d; lsu_valid = 1'b1; end
    for (int i = 0; i < 20 && !ok; i++) begin
      #2;
      ok = is_alu ? alu_ready : lsu_ready;
      cyc();
    end
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    chk("send_handshake", ok, 1'b1);
  endtask

  initial begin
    int iter;
    logic got;

    // Reset state, including ready gating while reset is asserted.
    #2;
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    #1;
    chk("rst_alu_ready", alu_ready, 1'b0);
    chk("rst_lsu_ready", lsu_ready, 1'b0);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_mask", mask, 32'd0);
    chk("rst_count", count, 3'd0);
    chk("rst_drops", drops, 16'd0);
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    cyc();

    // Single ALU write with the register file ready.
    wr_ready  = 1'b1;
    alu_addr  = 5'd5;
    alu_data  = 32'hDEADBEEF;
    alu_valid = 1'b1;
    #2;
    chk("t1_alu_ready", alu_ready, 1'b1);
    cyc();
    alu_valid = 1'b0;
    chk("t1_wr_valid", wr_valid, 1'b1);
    chk("t1_wr_addr", wr_addr, 5'd5);
    chk("t1_wr_data", wr_data, 32'hDEADBEEF);
    chk("t1_mask", mask, 32'h0000_0020);
    chk("t1_count", count, 3'd1);
    cyc();
    chk("t1_wr_valid_after", wr_valid, 1'b0);
    chk("t1_mask_after", mask, 32'd0);
    chk("t1_data_held", wr_data, 32'hDEADBEEF);

    // Fresh reset so the first contention goes to the ALU.
    rst = 1'b0;
    #2 rst = 1'b1;
    cyc();

    // Sustained contention alternates grants.
    drain_log.delete();
    alu_addr = 5'd1; alu_data = 32'hA1; alu_valid = 1'b1;
    lsu_addr = 5'd2; lsu_data = 32'hB2; lsu_valid = 1'b1;
    repeat (6) cyc();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    repeat (2) cyc();
    chk("t2_drain_len", drain_log.size(), 6);
    for (int k = 0; k < 6 && k < drain_log.size(); k++)
      chk("t2_drain_order", drain_log[k], (k % 2 == 0) ? 5'd1 : 5'd2);

    // Backpressure: four fill the buffer, the fifth waits for room.
    wr_ready = 1'b0;
    drain_log.delete();
    for (int k = 0; k < 4; k++) send(1'b1, 5'(10 + k), 32'h100 + 32'(k));
    chk("t3_count_full", count, 3'd4);
    alu_addr = 5'd14; alu_data = 32'h104; alu_valid = 1'b1;
    #2;
    chk("t3_fifth_blocked", alu_ready, 1'b0);
    cyc();
    chk("t3_still_blocked", alu_ready, 1'b0);
    chk("t3_count_hold", count, 3'd4);
    wr_ready = 1'b1;
    iter = -1;
    got  = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #2;
      got = alu_ready;
      if (got) iter = i;
      cyc();
    end
    alu_valid = 1'b0;
    chk("t3_fifth_accepted", got, 1'b1);
    chk("t3_fifth_wait", iter, 1);
    repeat (6) cyc();
    chk("t3_drain_len", drain_log.size(), 5);
    for (int k = 0; k < 5 && k < drain_log.size(); k++)
      chk("t3_drain_order", drain_log[k], 5'(10 + k));

    // x0 writes complete the handshake but never reach the register file.
    drain_log.delete();
    for (int k = 0; k < 3; k++) send(1'b0, 5'd0, 32'h55 + 32'(k));
    repeat (2) cyc();
    chk("t4_drops", drops, 16'd3);
    chk("t4_no_writes", drain_log.size(), 0);
    chk("t4_mask", mask, 32'd0);
    chk("t4_count", count, 3'd0);

    // Asynchronous reset with buffered writes outstanding.
    wr_ready = 1'b0;
    send(1'b1, 5'd7, 32'h7);
    send(1'b1, 5'd8, 32'h8);
    send(1'b1, 5'd9, 32'h9);
    chk("t5_count", count, 3'd3);
    chk("t5_mask", mask, 32'h0000_0380);
    chk("t5_wr_addr", wr_addr, 5'd7);
    alu_addr = 5'd3; alu_data = 32'h33; alu_valid = 1'b1;
    lsu_addr = 5'd4; lsu_data = 32'h44; lsu_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk("t5_rst_wr_valid", wr_valid, 1'b0);
    chk("t5_rst_wr_addr", wr_addr, 5'd0);
    chk("t5_rst_wr_data", wr_data, 32'd0);
    chk("t5_rst_mask", mask, 32'd0);
    chk("t5_rst_count", count, 3'd0);
    chk("t5_rst_drops", drops, 16'd0);
    chk("t5_rst_alu_ready", alu_ready, 1'b0);
    chk("t5_rst_lsu_ready", lsu_ready, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("t5_first_alu", alu_ready, 1'b1);
    chk("t5_first_lsu", lsu_ready, 1'b0);
    cyc();
    chk("t5_second_lsu", lsu_ready, 1'b1);
    chk("t5_second_alu", alu_ready, 1'b0);
    chk("t5_count_after", count, 3'd1);
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    wr_ready  = 1'b1;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
